// File: rtl/rsa_result_writer.sv
// Packs the RSA byte stream LSB-first into 256-bit words and writes them to DRAM over Avalon-MM.
// Write is asserted 1 cycle after the word's last byte; a full 2-entry FIFO stalls only byte 31 of a block.
module rsa_result_writer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256,
  parameter int BYTES  = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_blocks,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              avm_m0_waitrequest,
  output logic [ADDR_W-1:0] avm_m0_address,
  output logic              avm_m0_write,
  output logic [DATA_W-1:0] avm_m0_writedata,
  output logic [BYTES-1:0]  avm_m0_byteenable,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  blocks_written
);
  localparam int IDX_W = $clog2(BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, FIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  acc_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic [IDX_W-1:0]  byte_idx;
  logic [DATA_W-1:0] pack;
  logic [DATA_W-1:0] full_word;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        fifo_count;
  logic [1:0]        fifo_count_nxt;
  logic              write_q;
  logic              busy_q;
  logic              done_q;
  logic              byte_fire;
  logic              push;
  logic              pop;

  assign byte_ready = (state == RUN) && (acc_cnt < num_q) &&
                      ((byte_idx != LAST_IDX) || (fifo_count < 2'd2));
  assign byte_fire  = byte_valid && byte_ready;
  assign push       = byte_fire && (byte_idx == LAST_IDX);
  assign pop        = write_q && !avm_m0_waitrequest;

  // The last byte bypasses the pack register so the word is pushed in the same cycle it completes.
  always_comb begin
    full_word = pack;
    full_word[DATA_W-1 -: 8] = byte_data;
  end

  always_comb begin
    fifo_count_nxt = fifo_count;
    if (push && !pop)
      fifo_count_nxt = fifo_count + 2'd1;
    else if (pop && !push)
      fifo_count_nxt = fifo_count - 2'd1;
  end

  assign avm_m0_address    = base_q + (ADDR_W'(wr_cnt) * ADDR_W'(BYTES));
  assign avm_m0_writedata  = fifo_mem[rd_ptr];
  assign avm_m0_write      = write_q;
  assign avm_m0_byteenable = '1;
  assign busy              = busy_q;
  assign done              = done_q;
  assign blocks_written    = wr_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      base_q      <= '0;
      num_q       <= '0;
      acc_cnt     <= '0;
      wr_cnt      <= '0;
      byte_idx    <= '0;
      pack        <= '0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
      write_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (byte_fire) begin
        pack[8*byte_idx +: 8] <= byte_data;
        byte_idx <= push ? '0 : byte_idx + 1'b1;
      end
      if (push) begin
        fifo_mem[wr_ptr] <= full_word;
        wr_ptr  <= ~wr_ptr;
        acc_cnt <= acc_cnt + 1'b1;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        wr_cnt <= wr_cnt + 1'b1;
      end
      fifo_count <= fifo_count_nxt;
      // Write stays up while anything is queued, giving back-to-back bursts.
      write_q    <= (fifo_count_nxt != 2'd0);

      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            num_q    <= num_blocks;
            byte_idx <= '0;
            acc_cnt  <= '0;
            wr_cnt   <= '0;
            if (num_blocks == '0) begin
              state  <= FIN;
              done_q <= 1'b1;
            end else begin
              state  <= RUN;
              busy_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (acc_cnt == num_q)
            state <= FLUSH;
        end
        FLUSH: begin
          if ((fifo_count == 2'd0) && (wr_cnt == num_q)) begin
            state  <= FIN;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        FIN: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/rsa_result_writer.md
Name: rsa_result_writer

Overview:
- Downstream stage of the Avalon RSA wrapper.
- Accepts the RSA core's byte-serial result stream and packs every 32 bytes LSB-first into one 256-bit word.
- Buffers packed words in a 2-entry FIFO and writes them to DRAM over an Avalon-MM master at consecutive 32-byte addresses.
- Signals completion to the flag/control logic after a programmed number of blocks.

Parameters:
- ADDR_W, 32, Avalon address width.
- DATA_W, 256, Avalon data width; must equal 8*BYTES.
- BYTES, 32, bytes per block / per Avalon word.
- CNT_W, 16, width of the block counters.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; latches base_addr/num_blocks and starts a job.
- base_addr  in  ADDR_W  DRAM byte address of block 0.
- num_blocks  in  CNT_W  number of 256-bit blocks to write.
- byte_valid  in  1  result byte present.
- byte_data  in  8  result byte.
- byte_ready  out  1  writer accepts byte this cycle.
- avm_m0_waitrequest  in  1  Avalon slave stall.
- avm_m0_address  out  ADDR_W  write address.
- avm_m0_write  out  1  write request.
- avm_m0_writedata  out  DATA_W  write data.
- avm_m0_byteenable  out  BYTES  constant all-ones.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.
- blocks_written  out  CNT_W  blocks acknowledged by Avalon in current/last job.

Behaviour:
- Reset (reset=0, async): state IDLE, byte_idx=0, FIFO empty, wr_cnt=0, acc_cnt=0. Outputs: byte_ready=0, avm_m0_write=0, avm_m0_address=0, avm_m0_writedata=0, busy=0, done=0, blocks_written=0. Reset mid-job abandons the job, including any in-flight write.
- States: IDLE, RUN, FLUSH, FIN.
  - IDLE -> RUN on start. start latches base/num and clears byte_idx, acc_cnt, wr_cnt, blocks_written.
  - start with num_blocks=0: IDLE -> FIN, done pulses the next cycle, no writes.
  - start while busy is ignored.
  - RUN -> FLUSH when acc_cnt reaches num_blocks.
  - FLUSH -> FIN when FIFO empty and wr_cnt==num_blocks.
  - FIN -> IDLE after 1 cycle, done=1 during FIN.
  - busy=1 in RUN and FLUSH.
- Byte accept (byte_valid && byte_ready) writes byte_data to pack[8*byte_idx+:8], then byte_idx++.
- byte_ready = (state==RUN) && (acc_cnt<num_blocks) && (byte_idx!=31 || fifo_count<2). Bytes beyond the last block are never accepted.
- Accepting byte 31:
  - Pushes the full word (including that byte) into the FIFO in the same cycle.
  - byte_idx wraps to 0; acc_cnt++.
- Write master:
  - avm_m0_write is registered and goes high the cycle after a push into an empty FIFO.
  - Head word drives writedata; address = base + 32*wr_cnt, modulo 2^ADDR_W (wrap allowed).
  - Address, data and write are held stable while waitrequest=1.
  - Handshake completes when write && !waitrequest: pop, wr_cnt++, blocks_written++.
  - Next head word is presented the following cycle; back-to-back writes are allowed.
- Simultaneous push and pop: fifo_count is unchanged and order is preserved.
- FIFO full with byte 31 pending: byte_ready=0; bytes 0..30 of the next block may still be accepted.
- Throughput: 1 byte/cycle sustained when waitrequest=0. Latency from byte 31 accepted to avm_m0_write=1 is 1 cycle.

Test Plan:
- Single block: base=0x140, num=1, bytes 0x00..0x1F one per cycle, waitrequest=0 -> one write at 0x140, writedata=0x1F1E..0100, done pulse 2 cycles after write; blocks_written=1.
- Stall: num=3, waitrequest held high 100 cycles -> FIFO fills. byte_ready drops at byte 31 of block 2; address/data stable throughout. On release, writes go to base, base+0x20, base+0x40 in order.
- Boundaries: num=0 -> done one cycle after start with no avm_m0_write. base=0xFFFFFFE0, num=2 -> second address 0x00000000.
- Over-supply: num=1, byte_valid held high for 40 bytes -> exactly 32 accepted, byte_ready=0 afterward, one write.
- Reset mid-job: assert reset during a stalled write of block 1 of 3 -> all outputs zero immediately. A new start with num=1 then completes normally at its base.
- Ignored start: pulse start with different base while busy -> original job's addresses and num unaffected.
